// File: rtl/tinyalu_cmd_issuer_if.sv
// rtl/tinyalu_cmd_issuer_if.sv - command, TinyALU and response bus of the command issuer
// master: the issuer (accepts commands, drives the ALU, returns responses)
// slave : the environment (offers commands, acts as the ALU, consumes responses)
// cmd_*  : command stream in (valid/ready)
// alu_*  : TinyALU start/done handshake and operands
// rsp_*  : response stream out (valid/ready)
interface tinyalu_cmd_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_A;
  logic [7:0]  alu_B;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_done, alu_result, rsp_ready,
    output cmd_ready, alu_start, alu_op, alu_A, alu_B, rsp_valid, rsp_result, rsp_op, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_done, alu_result, rsp_ready,
    input  cmd_ready, alu_start, alu_op, alu_A, alu_B, rsp_valid, rsp_result, rsp_op, rsp_err
  );
endinterface

// File: rtl/tinyalu_cmd_issuer.sv
// rtl/tinyalu_cmd_issuer.sv - buffers ALU commands and issues them one at a time to the TinyALU
// clk        : rising-edge clock
// reset_n    : asynchronous active-low reset
// bus        : tinyalu_cmd_issuer_if.master (command in, TinyALU handshake, response out)
// fifo_count : current command FIFO occupancy
module tinyalu_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  tinyalu_cmd_issuer_if.master   bus,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ILL = 3'b110;
  localparam logic [2:0] OP_RST = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_BUSY, S_NOP, S_GAP, S_RESP} state_t;

  state_t state, state_next;

  // command FIFO
  logic [18:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ready_q;  // holds cmd_ready low until the first clock after reset release
  logic          push, pop;
  logic [2:0]    head_op;
  logic [7:0]    head_a, head_b;

  // operation / response registers
  logic [2:0]    alu_op_q;
  logic [7:0]    alu_a_q, alu_b_q;
  logic [15:0]   rsp_result_q;
  logic [2:0]    rsp_op_q;
  logic          rsp_err_q;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign bus.cmd_ready = ready_q && (count != CW'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state == S_IDLE) && (count != '0) && !bus.rsp_valid;
  assign {head_op, head_a, head_b} = mem[rd_ptr];
  assign fifo_count    = count;
  // last cycle of the start window; done in the same cycle still wins
  assign tmo_hit       = (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (pop) begin
          case (head_op)
            OP_NOP:         state_next = S_NOP;
            OP_RST, OP_ILL: state_next = S_RESP;
            default:        state_next = S_BUSY;
          endcase
        end
      end
      S_BUSY:  if (bus.alu_done || tmo_hit) state_next = S_GAP;
      S_NOP:   state_next = S_RESP;
      S_GAP:   state_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs (decoded from state so reset clears them asynchronously)
  always_comb begin
    bus.alu_start  = (state == S_BUSY) || (state == S_NOP);
    bus.rsp_valid  = (state == S_RESP);
    bus.alu_op     = alu_op_q;
    bus.alu_A      = alu_a_q;
    bus.alu_B      = alu_b_q;
    bus.rsp_result = rsp_result_q;
    bus.rsp_op     = rsp_op_q;
    bus.rsp_err    = rsp_err_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_op_q     <= '0;
      rsp_err_q    <= 1'b0;
      tmo_cnt      <= '0;
    end else begin
      tmo_cnt <= (state == S_BUSY) ? tmo_cnt + 1'b1 : '0;
      if (pop) begin
        rsp_op_q     <= head_op;
        rsp_result_q <= '0;
        rsp_err_q    <= (head_op == OP_ILL);
        // rst_op and the illegal code never reach the ALU bus
        if (head_op != OP_RST && head_op != OP_ILL) begin
          alu_op_q <= head_op;
          alu_a_q  <= head_a;
          alu_b_q  <= head_b;
        end
      end
      if (state == S_BUSY) begin
        if (bus.alu_done) begin
          rsp_result_q <= bus.alu_result;
          rsp_err_q    <= 1'b0;
        end else if (tmo_hit) begin
          rsp_result_q <= '0;
          rsp_err_q    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tinyalu_cmd_issuer.sv
// tb/tb_tinyalu_cmd_issuer.sv - directed self-checking bench for tinyalu_cmd_issuer
module tb_tinyalu_cmd_issuer;

  logic       clk;
  logic       reset_n;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  // behavioural TinyALU: answers after alu_lat cycles of start when enabled
  bit alu_en   = 0;
  int alu_lat  = 1;
  int busy_cyc = 0;
  int start_cnt = 0;
  logic [2:0] start_op_or = 3'b000;

  tinyalu_cmd_issuer_if bus ();

  tinyalu_cmd_issuer #(.DEPTH(4), .TIMEOUT(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b001:  return {8'h00, a} + {8'h00, b};
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return {8'h00, a} * {8'h00, b};
      default: return {a, b};
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      bus.alu_done   = 1'b0;
      bus.alu_result = 16'h0000;
      busy_cyc       = 0;
    end else if (bus.alu_start && !bus.alu_done && bus.alu_op != 3'b000) begin
      busy_cyc++;
      if (alu_en && busy_cyc >= alu_lat) begin
        bus.alu_done   = 1'b1;
        bus.alu_result = calc(bus.alu_op, bus.alu_A, bus.alu_B);
      end
    end else begin
      bus.alu_done = 1'b0;
      if (!bus.alu_start) busy_cyc = 0;
    end
  end

  always @(negedge clk) begin
    if (bus.alu_start) begin
      start_cnt++;
      start_op_or = start_op_or | bus.alu_op;
    end
  end

  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL push_timeout: cmd_ready got 0 for %0d cycles want 1", n);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string name, input logic [15:0] res, input logic [2:0] op, input logic err);
    int n = 0;
    bus.rsp_ready = 1'b1;
    while (!bus.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid: rsp_valid got %b want 1", name, bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_result !== res) begin
      failures++;
      $display("FAIL %s_result: got %h want %h", name, bus.rsp_result, res);
    end
    checks++;
    if (bus.rsp_op !== op) begin
      failures++;
      $display("FAIL %s_op: got %b want %b", name, bus.rsp_op, op);
    end
    checks++;
    if (bus.rsp_err !== err) begin
      failures++;
      $display("FAIL %s_err: got %b want %b", name, bus.rsp_err, err);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.alu_start, bus.rsp_valid} !== 3'b000 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs: ready/start/valid=%b count=%0d want 000 count=0",
               {bus.cmd_ready, bus.alu_start, bus.rsp_valid}, fifo_count);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready: got %b want 0", bus.cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after: got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_add();
    int n = 0;
    int hi = 0;
    alu_en  = 1;
    alu_lat = 1;
    push(3'b001, 8'hFF, 8'h01);
    while (!bus.alu_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({bus.alu_op, bus.alu_A, bus.alu_B} !== {3'b001, 8'hFF, 8'h01}) begin
      failures++;
      $display("FAIL add_alu_bus: op=%b A=%h B=%h want 001 ff 01", bus.alu_op, bus.alu_A, bus.alu_B);
    end
    while (bus.alu_start && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    checks++;
    if (hi != 1) begin
      failures++;
      $display("FAIL add_start_len: got %0d want 1", hi);
    end
    get_rsp("add", 16'h0100, 3'b001, 1'b0);
  endtask

  task automatic test_fifo_full();
    alu_en  = 0;
    alu_lat = 2;
    push(3'b001, 8'h01, 8'h02);
    push(3'b010, 8'hF0, 8'h3C);
    push(3'b011, 8'hF0, 8'h3C);
    push(3'b100, 8'h03, 8'h05);
    push(3'b001, 8'h10, 8'h20);
    checks++;
    if (fifo_count !== 3'd4 || bus.cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_count: count=%0d ready=%b want 4 0", fifo_count, bus.cmd_ready);
    end
    alu_en = 1;
    get_rsp("full0", 16'h0003, 3'b001, 1'b0);
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd3 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_recover: count=%0d ready=%b want 3 1", fifo_count, bus.cmd_ready);
    end
    get_rsp("full1", 16'h0030, 3'b010, 1'b0);
    get_rsp("full2", 16'h00CC, 3'b011, 1'b0);
    get_rsp("full3", 16'h000F, 3'b100, 1'b0);
    get_rsp("full4", 16'h0030, 3'b001, 1'b0);
  endtask

  task automatic test_rsp_hold();
    int n = 0;
    int bad = 0;
    alu_en  = 1;
    alu_lat = 1;
    push(3'b100, 8'h10, 8'h10);
    push(3'b001, 8'h01, 8'h01);
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'h0100 || fifo_count !== 3'd1 || bus.alu_start !== 1'b0) begin
        failures++;
        bad++;
        $display("FAIL hold_stable: cyc=%0d valid=%b result=%h count=%0d start=%b want 1 0100 1 0",
                 i, bus.rsp_valid, bus.rsp_result, fifo_count, bus.alu_start);
      end
      @(negedge clk);
    end
    get_rsp("hold_mul", 16'h0100, 3'b100, 1'b0);
    get_rsp("hold_add", 16'h0002, 3'b001, 1'b0);
  endtask

  task automatic test_timeout();
    int n = 0;
    int hi = 0;
    alu_en = 0;
    push(3'b101, 8'h05, 8'h06);
    while (!bus.alu_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    while (bus.alu_start && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    checks++;
    if (hi != 32) begin
      failures++;
      $display("FAIL timeout_start_len: got %0d want 32", hi);
    end
    get_rsp("timeout", 16'h0000, 3'b101, 1'b1);
    alu_en  = 1;
    alu_lat = 1;
    push(3'b001, 8'h07, 8'h08);
    get_rsp("after_timeout", 16'h000F, 3'b001, 1'b0);
  endtask

  task automatic test_special_ops();
    int base;
    alu_en  = 1;
    alu_lat = 1;
    repeat (2) @(negedge clk);
    base        = start_cnt;
    start_op_or = 3'b000;
    push(3'b000, 8'h11, 8'h22);
    push(3'b111, 8'h33, 8'h44);
    push(3'b110, 8'h55, 8'h66);
    get_rsp("nop", 16'h0000, 3'b000, 1'b0);
    get_rsp("rst", 16'h0000, 3'b111, 1'b0);
    get_rsp("ill", 16'h0000, 3'b110, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt - base != 1) begin
      failures++;
      $display("FAIL special_start_cycles: got %0d want 1", start_cnt - base);
    end
    checks++;
    if (start_op_or !== 3'b000) begin
      failures++;
      $display("FAIL special_start_op: got %b want 000", start_op_or);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    alu_en = 0;
    push(3'b001, 8'h01, 8'h01);
    push(3'b010, 8'h02, 8'h02);
    push(3'b011, 8'h03, 8'h03);
    push(3'b100, 8'h04, 8'h04);
    @(negedge clk);
    checks++;
    if (bus.alu_start !== 1'b1 || fifo_count !== 3'd3) begin
      failures++;
      $display("FAIL mid_pre: start=%b count=%0d want 1 3", bus.alu_start, fifo_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.alu_start !== 1'b0) begin
      failures++;
      $display("FAIL mid_async_start: got %b want 0", bus.alu_start);
    end
    @(negedge clk);
    reset_n = 1'b1;
    alu_en  = 1;
    @(negedge clk);
    base = start_cnt;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (fifo_count !== 3'd0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL mid_after: cyc=%0d count=%0d valid=%b ready=%b want 0 0 1",
                 i, fifo_count, bus.rsp_valid, bus.cmd_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (start_cnt != base) begin
      failures++;
      $display("FAIL mid_no_activity: start cycles got %0d want 0", start_cnt - base);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 8'h00;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_fifo_full();
    test_rsp_hold();
    test_timeout();
    test_special_ops();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
